// File: rtl/lcd_score_writer.sv
// Snapshots both Pong scores and streams one 34-byte LCD frame (two DDRAM
// address commands plus two 16-character lines) as spaced write strobes.
module lcd_score_writer #(
  parameter int GAP_CYCLES = 2,
  parameter int SCORE_W    = 7
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [SCORE_W-1:0] score_l,
  input  logic [SCORE_W-1:0] score_r,
  input  logic               update,
  input  logic               lcd_busy,
  output logic               write_en,
  output logic [7:0]         data_out,
  output logic               is_cmd,
  output logic               frame_busy,
  output logic               frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [5:0] IDX_LAST = 6'd33;

  function automatic logic [6:0] sat99(input logic [SCORE_W-1:0] s);
    if (32'(s) > 32'd99) return 7'd99;
    return 7'(s);
  endfunction

  function automatic logic [3:0] tens(input logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic logic [3:0] ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  // Returns {is_cmd, byte} for frame position idx.
  function automatic logic [8:0] frame_byte(input logic [5:0] idx,
                                            input logic [3:0] l1, input logic [3:0] l0,
                                            input logic [3:0] r1, input logic [3:0] r0);
    case (idx)
      6'd0:                return 9'h180;
      6'd1, 6'd12, 6'd18:  return 9'h050;
      6'd2:                return 9'h031;
      6'd3, 6'd14:         return 9'h03A;
      6'd4:                return {1'b0, 4'h3, l1};
      6'd5:                return {1'b0, 4'h3, l0};
      6'd13:               return 9'h032;
      6'd15:               return {1'b0, 4'h3, r1};
      6'd16:               return {1'b0, 4'h3, r0};
      6'd17:               return 9'h1C0;
      6'd19:               return 9'h04F;
      6'd20:               return 9'h04E;
      6'd21:               return 9'h047;
      default:             return 9'h020;
    endcase
  endfunction

  state_t           r_state, w_state;
  logic [5:0]       r_idx, w_idx;
  logic [GAP_W-1:0] r_gap, w_gap;
  logic             r_last, w_last;
  logic             r_pending, w_pending;
  logic [3:0]       r_l1, r_l0, r_r1, r_r0;
  logic [3:0]       w_l1, w_l0, w_r1, w_r0;
  logic             r_we, w_we;
  logic [7:0]       r_data, w_data;
  logic             r_cmd, w_cmd;
  logic             r_fbusy, w_fbusy;
  logic             r_fdone, w_fdone;

  logic [6:0]       w_sat_l, w_sat_r;
  logic [8:0]       w_byte;

  assign w_sat_l = sat99(score_l);
  assign w_sat_r = sat99(score_r);
  assign w_byte  = frame_byte(r_idx, r_l1, r_l0, r_r1, r_r0);

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_gap     = r_gap;
    w_last    = r_last;
    w_pending = r_pending | update;
    w_l1      = r_l1;
    w_l0      = r_l0;
    w_r1      = r_r1;
    w_r0      = r_r0;
    w_we      = 1'b0;
    w_data    = r_data;
    w_cmd     = r_cmd;
    w_fdone   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // An update arriving in the same cycle is served by this frame.
        if (r_pending || update) begin
          w_state   = S_LATCH;
          w_pending = 1'b0;
        end
      end
      S_LATCH: begin
        w_l1    = tens(w_sat_l);
        w_l0    = ones(w_sat_l);
        w_r1    = tens(w_sat_r);
        w_r0    = ones(w_sat_r);
        w_idx   = 6'd0;
        w_gap   = '0;
        w_last  = 1'b0;
        w_state = S_SEND;
      end
      S_SEND: begin
        if (!lcd_busy) begin
          w_we   = 1'b1;
          w_cmd  = w_byte[8];
          w_data = w_byte[7:0];
          w_last = (r_idx == IDX_LAST);
          if (r_idx != IDX_LAST) w_idx = r_idx + 6'd1;
          w_gap  = '0;
          if (GAP_CYCLES == 0) w_state = (r_idx == IDX_LAST) ? S_DONE : S_SEND;
          else                 w_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_gap   = '0;
          w_state = r_last ? S_DONE : S_SEND;
        end else begin
          w_gap = r_gap + GAP_W'(1);
        end
      end
      S_DONE: begin
        w_fdone = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    w_fbusy = (w_state != S_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_idx     <= 6'd0;
      r_gap     <= '0;
      r_last    <= 1'b0;
      r_pending <= 1'b1;
      r_l1      <= 4'd0;
      r_l0      <= 4'd0;
      r_r1      <= 4'd0;
      r_r0      <= 4'd0;
      r_we      <= 1'b0;
      r_data    <= 8'h00;
      r_cmd     <= 1'b0;
      r_fbusy   <= 1'b0;
      r_fdone   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_gap     <= w_gap;
      r_last    <= w_last;
      r_pending <= w_pending;
      r_l1      <= w_l1;
      r_l0      <= w_l0;
      r_r1      <= w_r1;
      r_r0      <= w_r0;
      r_we      <= w_we;
      r_data    <= w_data;
      r_cmd     <= w_cmd;
      r_fbusy   <= w_fbusy;
      r_fdone   <= w_fdone;
    end
  end

  assign write_en   = r_we;
  assign data_out   = r_data;
  assign is_cmd     = r_cmd;
  assign frame_busy = r_fbusy;
  assign frame_done = r_fdone;

endmodule
